key_sw_capture: RTL and testbench
=================================

Name: key_sw_capture

Overview:
- Input-side front end for the network: conditions the raw push-button and the 9 slide switches.
- Issues a single-cycle start strobe to the network, together with a frozen copy of the switch pattern.
- Holds off further presses until the network reports completion and the button has been released.
- Sits between the board pins (sw, key) and the network's sw/en inputs, mirroring the display path on the output side.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable clk cycles required to accept a press or a release (20 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- SW_W, 9, width of the switch vector.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  SW_W  raw slide switches, asynchronous to clk.
- key  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
- finish  input  1  completion flag from the network; level or pulse.
- start  output  1  one-cycle run strobe to the network.
- pattern  output  SW_W  switch vector latched at acceptance of a press.
- busy  output  1  high from start until a finish rising edge is detected.

Behaviour:
- Synchronisers:
  - 2-flop synchroniser on key, reset value 1 (released); output is key_s.
  - 2-flop synchroniser on sw, reset value 0; output is sw_s.
- Finish edge detect:
  - finish_d is a registered copy of finish, reset 0.
  - done_evt = finish & ~finish_d.
  - A finish level left high from a previous run never completes a new run.
- Reset values: start=0, busy=0, pattern=0, cnt=0, state=REL.
  - Reset takes effect asynchronously on rst_n low, mid-operation included.
  - Because reset lands in REL, a button held through reset never triggers a run; it must first be released for DEBOUNCE_CYCLES cycles.
- FSM states, evaluated each clk edge:
  - IDLE:
    - key_s==0 -> PRESS, cnt<=0.
    - Otherwise stay in IDLE.
  - PRESS:
    - key_s==1 (bounce) -> IDLE, cnt<=0.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> FIRE, pattern<=sw_s.
    - Else cnt<=cnt+1.
  - FIRE:
    - start=1 for exactly this one cycle; busy=1.
    - Unconditionally -> WAIT; finish is ignored in this state.
  - WAIT:
    - busy=1; key activity is ignored.
    - done_evt -> REL, cnt<=0.
  - REL:
    - busy=0.
    - key_s==0 -> cnt<=0 and stay.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Else cnt<=cnt+1.
- Output decode:
  - start is a registered output, high only while in FIRE.
  - busy is registered, high in FIRE and WAIT.
  - pattern changes only on the PRESS->FIRE transition and is stable for the entire run.
- Press latency (edge 0 = first clk edge sampling key low at the synchroniser input):
  - key_s goes low after edge 1.
  - PRESS is entered at edge 2.
  - FIRE is entered at edge DEBOUNCE_CYCLES+2, so start is high during the cycle after that edge.
- Counter boundaries:
  - cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - DEBOUNCE_CYCLES=1 is legal: accept on the first stable cycle.
- Simultaneous events:
  - done_evt and key low in the same WAIT cycle -> REL, with cnt reset on the next cycle because key is low.
  - A new press while in WAIT or REL produces no start; no press is queued.
- sw changes during a run have no effect on pattern until the next accepted press.

Test Plan (simulate with DEBOUNCE_CYCLES=4):
- Clean press: after reset, hold key=1 for 10 cycles, set sw=9'h1A5, drive key=0 for 20 cycles.
  - start pulses high exactly 1 cycle, 6 edges after the first low sample.
  - pattern=9'h1A5; busy rises with start.
- Bounce rejection: key low 3 cycles, high 1, low 3, high.
  - No start; pattern stays 0; state returns to IDLE.
- Run completion: after a clean press, change sw to 9'h0FF mid-run, then drive finish 0->1 (held high).
  - busy drops one cycle after the rising edge; pattern stays 9'h1A5.
  - Keep finish high, release key 4+ cycles, press again: a new start occurs; busy stays high until the next finish 0->1 (low then high).
- Press during busy: press key cleanly while in WAIT.
  - No second start; after finish, the key must be released ≥4 stable cycles before the next press is accepted.
- Reset with key held: assert rst_n=0 mid-WAIT with key=0, release reset with key still 0 for 50 cycles.
  - start, busy and pattern are 0 immediately on rst_n low; no start while key stays low.
  - A release of 4+ cycles followed by a press fires normally.
- Release bounce: after finish, key high 3 cycles, low 1, high 3.
  - Still in REL (a press now is ignored); IDLE is reached only after 4 consecutive high cycles.

Source files
------------

// File: rtl/key_sw_capture.sv
// Push-button / slide-switch front end: synchronises and debounces the key, then issues
// a one-cycle start with a frozen switch pattern, and re-arms only after finish and a clean release.
module key_sw_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SW_W            = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw,
  input  logic            key,
  input  logic            finish,
  output logic            start,
  output logic [SW_W-1:0] pattern,
  output logic            busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRESS = 3'd1;
  localparam logic [2:0] FIRE  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] REL   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            key_p0;
  logic            key_s;
  logic [SW_W-1:0] sw_p0;
  logic [SW_W-1:0] sw_s;
  logic            finish_d;
  logic            done_evt;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SW_W-1:0]  pattern_nxt;

  // Input synchronisers; the key resets to "released" so a held button cannot fire out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0   <= 1'b1;
      key_s    <= 1'b1;
      sw_p0    <= '0;
      sw_s     <= '0;
      finish_d <= 1'b0;
    end else begin
      key_p0   <= key;
      key_s    <= key_p0;
      sw_p0    <= sw;
      sw_s     <= sw_p0;
      finish_d <= finish;
    end
  end

  assign done_evt = finish & ~finish_d;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end
      PRESS: begin
        if (key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = FIRE;
          pattern_nxt = sw_s;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FIRE: state_nxt = WAIT;
      WAIT: begin
        if (done_evt) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end
      end
      REL: begin
        if (!key_s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so start/busy line up with FIRE/WAIT occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REL;
      cnt     <= '0;
      pattern <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pattern <= pattern_nxt;
      start   <= (state_nxt == FIRE);
      busy    <= (state_nxt == FIRE) || (state_nxt == WAIT);
    end
  end

endmodule

// File: tb/tb_key_sw_capture.sv
// Bench for key_sw_capture: directed scenarios and random key/finish traffic against a
// run-length reference model (consecutive stable samples, run phases) with DEBOUNCE_CYCLES=4.
module tb_key_sw_capture;
  localparam int D  = 4;
  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key = 1'b1;
  logic          finish = 1'b0;
  logic [SW-1:0] sw = '0;
  logic          start;
  logic          busy;
  logic [SW-1:0] pattern;

  int nvec = 0;
  int nerr = 0;

  // Reference model: phase 0 ready, 1 firing, 2 running, 3 cooling down after finish
  int            m_phase;
  int            m_run;
  logic          m_k1, m_k2, m_fprev, m_start, m_busy;
  logic [SW-1:0] m_s1, m_s2, m_pattern;

  key_sw_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .SW_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key(key), .finish(finish),
    .start(start), .pattern(pattern), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    m_phase = 3; m_run = 0; m_k1 = 1'b1; m_k2 = 1'b1; m_fprev = 1'b0;
    m_s1 = '0; m_s2 = '0; m_pattern = '0; m_start = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step;
    logic          ks;
    logic [SW-1:0] ss;
    logic          fe;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ks = m_k2; ss = m_s2; fe = finish & ~m_fprev;
    m_k2 = m_k1; m_k1 = key; m_s2 = m_s1; m_s1 = sw; m_fprev = finish;
    case (m_phase)
      0: begin
        m_run = ks ? 0 : m_run + 1;
        if (m_run == D + 1) begin m_phase = 1; m_pattern = ss; end
      end
      1: m_phase = 2;
      2: if (fe) begin m_phase = 3; m_run = 0; end
      default: begin
        m_run = ks ? m_run + 1 : 0;
        if (m_run == D) begin m_phase = 0; m_run = 0; end
      end
    endcase
    m_start = (m_phase == 1);
    m_busy  = (m_phase == 1) || (m_phase == 2);
  endtask

  task automatic cyc(input logic k, input logic f, input logic [SW-1:0] s);
    key = k; finish = f; sw = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({start, busy, pattern} !== '0) begin
      nerr++; $display("FAIL reset_state: start/busy/pattern=%b/%b/%h expected 0/0/000", start, busy, pattern);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, '0);
      nvec++;
      if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
        nerr++; $display("FAIL reset_idle cyc%0d: got %b/%b/%h expected %b/%b/%h", i, start, busy, pattern, m_start, m_busy, m_pattern);
      end
    end
  endtask

  task automatic test_bounce;
    int kv[4] = '{0, 1, 0, 1};
    int ln[4] = '{3, 1, 3, 8};
    int nst = 0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < ln[g]; i++) begin
        cyc(kv[g] != 0, 1'b0, 9'h0C3);
        nvec++;
        if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
          nerr++; $display("FAIL bounce seg%0d cyc%0d: got %b/%b/%h expected %b/%b/%h", g, i, start, busy, pattern, m_start, m_busy, m_pattern);
        end
        if (start) nst++;
      end
    end
    nvec++;
    if (nst != 0 || pattern !== '0) begin
      nerr++; $display("FAIL bounce_result: starts=%0d pattern=%h expected 0 starts pattern 000", nst, pattern);
    end
  endtask

  task automatic test_clean_press;
    int   nst = 0;
    int   first = -1;
    logic busy_at_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 9'h1A5);
      nvec++;
      if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
        nerr++; $display("FAIL clean_press cyc%0d: got %b/%b/%h expected %b/%b/%h", i, start, busy, pattern, m_start, m_busy, m_pattern);
      end
      if (start) begin
        nst++;
        if (first < 0) begin first = i; busy_at_start = busy; end
      end
    end
    nvec++;
    if (nst != 1 || first != D + 2 || busy_at_start !== 1'b1) begin
      nerr++; $display("FAIL clean_press_timing: starts=%0d at edge %0d busy=%b expected 1 start at edge %0d busy=1", nst, first, busy_at_start, D + 2);
    end
    nvec++;
    if ({busy, pattern} !== {1'b1, 9'h1A5}) begin
      nerr++; $display("FAIL clean_press_pattern: busy/pattern=%b/%h expected 1/1a5", busy, pattern);
    end
  endtask

  task automatic test_run_completion;
    int            kv[7] = '{0, 0, 0, 1, 0, 0, 0};
    int            fv[7] = '{0, 1, 1, 1, 1, 0, 1};
    int            ln[7] = '{5, 1, 3, 6, 15, 2, 1};
    logic          eb[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [SW-1:0] ep[7] = '{9'h1A5, 9'h1A5, 9'h1A5, 9'h1A5, 9'h0FF, 9'h0FF, 9'h0FF};
    int nst = 0;
    for (int g = 0; g < 7; g++) begin
      for (int i = 0; i < ln[g]; i++) begin
        cyc(kv[g] != 0, fv[g] != 0, 9'h0FF);
        nvec++;
        if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
          nerr++; $display("FAIL completion seg%0d cyc%0d: got %b/%b/%h expected %b/%b/%h", g, i, start, busy, pattern, m_start, m_busy, m_pattern);
        end
        if (start) nst++;
      end
      nvec++;
      if ({busy, pattern} !== {eb[g], ep[g]}) begin
        nerr++; $display("FAIL completion_seg%0d: busy/pattern=%b/%h expected %b/%h", g, busy, pattern, eb[g], ep[g]);
      end
    end
    nvec++;
    if (nst != 1) begin
      nerr++; $display("FAIL completion_restart: starts=%0d expected 1", nst);
    end
  endtask

  task automatic test_press_during_busy;
    int            kv[11] = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0};
    int            fv[11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
    int            ln[11] = '{6, 10, 5, 10, 1, 10, 3, 10, 6, 10, 1};
    logic [SW-1:0] sv[11] = '{9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h133, 9'h133, 9'h133};
    logic          eb[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [SW-1:0] ep[11] = '{9'h0FF, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h133, 9'h133};
    int nst = 0;
    for (int g = 0; g < 11; g++) begin
      for (int i = 0; i < ln[g]; i++) begin
        cyc(kv[g] != 0, fv[g] != 0, sv[g]);
        nvec++;
        if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
          nerr++; $display("FAIL busy_press seg%0d cyc%0d: got %b/%b/%h expected %b/%b/%h", g, i, start, busy, pattern, m_start, m_busy, m_pattern);
        end
        if (start) nst++;
      end
      nvec++;
      if ({busy, pattern} !== {eb[g], ep[g]}) begin
        nerr++; $display("FAIL busy_press_seg%0d: busy/pattern=%b/%h expected %b/%h", g, busy, pattern, eb[g], ep[g]);
      end
    end
    nvec++;
    if (nst != 2) begin
      nerr++; $display("FAIL busy_press_starts: starts=%0d expected 2", nst);
    end
  endtask

  task automatic test_release_bounce;
    int            kv[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    int            fv[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    int            ln[8] = '{3, 1, 3, 10, 4, 10, 1, 1};
    logic          eb[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [SW-1:0] ep[8] = '{9'h133, 9'h133, 9'h133, 9'h133, 9'h133, 9'h0AA, 9'h0AA, 9'h0AA};
    int nst = 0;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < ln[g]; i++) begin
        cyc(kv[g] != 0, fv[g] != 0, 9'h0AA);
        nvec++;
        if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
          nerr++; $display("FAIL rel_bounce seg%0d cyc%0d: got %b/%b/%h expected %b/%b/%h", g, i, start, busy, pattern, m_start, m_busy, m_pattern);
        end
        if (start) nst++;
      end
      nvec++;
      if ({busy, pattern} !== {eb[g], ep[g]}) begin
        nerr++; $display("FAIL rel_bounce_seg%0d: busy/pattern=%b/%h expected %b/%h", g, busy, pattern, eb[g], ep[g]);
      end
    end
    nvec++;
    if (nst != 1) begin
      nerr++; $display("FAIL rel_bounce_starts: starts=%0d expected 1", nst);
    end
  endtask

  task automatic test_reset_key_held;
    int kv[6] = '{1, 0, 1, 0, 0, 0};
    int fv[6] = '{1, 1, 1, 1, 0, 1};
    int ln[6] = '{6, 10, 5, 10, 1, 1};
    int nst = 0;
    int held = 0;
    for (int g = 0; g < 6; g++) begin
      if (g == 2) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        nvec++;
        if ({start, busy, pattern} !== '0) begin
          nerr++; $display("FAIL async_reset: start/busy/pattern=%b/%b/%h expected 0/0/000", start, busy, pattern);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 9'h1C3);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
          cyc(1'b0, 1'b1, 9'h1C3);
          nvec++;
          if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
            nerr++; $display("FAIL held_key cyc%0d: got %b/%b/%h expected %b/%b/%h", i, start, busy, pattern, m_start, m_busy, m_pattern);
          end
          if (start || busy) held++;
        end
        nvec++;
        if (held != 0 || pattern !== '0) begin
          nerr++; $display("FAIL held_key_result: active cycles=%0d pattern=%h expected 0 and 000", held, pattern);
        end
      end
      for (int i = 0; i < ln[g]; i++) begin
        cyc(kv[g] != 0, fv[g] != 0, 9'h1C3);
        nvec++;
        if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
          nerr++; $display("FAIL reset_run seg%0d cyc%0d: got %b/%b/%h expected %b/%b/%h", g, i, start, busy, pattern, m_start, m_busy, m_pattern);
        end
        if (start) nst++;
      end
    end
    nvec++;
    if (nst != 2 || pattern !== 9'h1C3 || busy !== 1'b0) begin
      nerr++; $display("FAIL reset_run_result: starts=%0d pattern=%h busy=%b expected 2/1c3/0", nst, pattern, busy);
    end
  endtask

  task automatic test_random;
    int            hold = 0;
    logic          k = 1'b1;
    logic          f = 1'b0;
    logic [SW-1:0] s = '0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        k = ($urandom_range(0, 1) != 0);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 24) == 0) f = ~f;
      if ($urandom_range(0, 7) == 0) s = SW'($urandom);
      cyc(k, f, s);
      nvec++;
      if ({start, busy, pattern} !== {m_start, m_busy, m_pattern}) begin
        nerr++; $display("FAIL random cyc%0d: got %b/%b/%h expected %b/%b/%h", i, start, busy, pattern, m_start, m_busy, m_pattern);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_run_completion();
    test_press_during_busy();
    test_release_bounce();
    test_reset_key_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
